// File: rtl/sram_pin_pkg.sv
// Shared definitions for the host-side pin-level SRAM initiator.
package sram_pin_pkg;

    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned RD_LAT_DEF   = 4;
    localparam int unsigned WR2RD_DEF    = 1;
    localparam int unsigned PIN_WE       = 7;
    localparam int unsigned PIN_RE       = 6;
    localparam int unsigned PIN_ADDR_MSB = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_GAP  = 2'd1,
        RD_WAIT = 2'd2,
        RSP     = 2'd3
    } state_e;

    // Layout of the uio control pins: [7]=we, [6]=re, [5:0]=addr
    typedef struct packed {
        logic              we;
        logic              re;
        logic [ADDR_W-1:0] addr;
    } pin_ctrl_t;

endpackage

// File: rtl/sram_pin_host.sv
// Turns a valid/ready read/write request stream into the SRAM tile pin protocol
// and returns read bytes on a held valid/ready response port.
module sram_pin_host
    import sram_pin_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEF,
    parameter int unsigned WR2RD  = WR2RD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] pin_data_o,
    output logic [7:0]        pin_ctrl_o,
    input  logic [DATA_W-1:0] pin_rdata_i
);

    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned GAP_W = (WR2RD > 1) ? $clog2(WR2RD) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WR2RD - 1);

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              wr_last_q, wr_last_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0] pin_data_q, pin_data_d;
    pin_ctrl_t         pin_ctrl_q, pin_ctrl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            wr_last_q   <= 1'b0;
            rd_addr_q   <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            pin_data_q  <= '0;
            pin_ctrl_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            wr_last_q   <= wr_last_d;
            rd_addr_q   <= rd_addr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            pin_data_q  <= pin_data_d;
            pin_ctrl_q  <= pin_ctrl_d;
        end
    end

    // Strobes are single-cycle pulses; address and data hold their last value.
    always_comb begin
        state_d         = state_q;
        lat_cnt_d       = lat_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        wr_last_d       = wr_last_q;
        rd_addr_d       = rd_addr_q;
        req_ready_d     = req_ready_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        pin_data_d      = pin_data_q;
        pin_ctrl_d      = pin_ctrl_q;
        pin_ctrl_d.we   = 1'b0;
        pin_ctrl_d.re   = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                wr_last_d   = 1'b0;
                if (req_valid && req_ready_q) begin
                    if (req_we) begin
                        pin_data_d      = req_wdata;
                        pin_ctrl_d.we   = 1'b1;
                        pin_ctrl_d.addr = req_addr;
                        wr_last_d       = 1'b1;
                    end else if (wr_last_q) begin
                        // Read right behind a write: hold it off the pins for the turnaround gap
                        rd_addr_d   = req_addr;
                        gap_cnt_d   = GAP_LOAD;
                        req_ready_d = 1'b0;
                        state_d     = WR_GAP;
                    end else begin
                        pin_ctrl_d.re   = 1'b1;
                        pin_ctrl_d.addr = req_addr;
                        lat_cnt_d       = LAT_LOAD;
                        req_ready_d     = 1'b0;
                        state_d         = RD_WAIT;
                    end
                end
            end
            WR_GAP: begin
                if (gap_cnt_q == '0) begin
                    pin_ctrl_d.re   = 1'b1;
                    pin_ctrl_d.addr = rd_addr_q;
                    lat_cnt_d       = LAT_LOAD;
                    state_d         = RD_WAIT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    rsp_data_d  = pin_rdata_i;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign pin_data_o = pin_data_q;
    assign pin_ctrl_o = pin_ctrl_q;

endmodule

// File: tb/tb_sram_pin_host.sv
// Closed-loop bench: host initiator wired to a behavioural pipelined SRAM tile,
// with a reference memory and response scoreboard.
module tb_sram_pin_host;

    localparam int unsigned RD_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_we;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data, pin_data, pin_ctrl, pin_rdata;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [7:0] ref_mem  [64];
    logic [7:0] sram_mem [64];
    logic [7:0] sb[$];
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       rnd_rsp;

    sram_pin_host #(.RD_LAT(RD_LAT), .WR2RD(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .pin_data_o  (pin_data),
        .pin_ctrl_o  (pin_ctrl),
        .pin_rdata_i (pin_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM tile model: re sampled at edge 1, data valid on the pins only for the
    // cycle ending at edge RD_LAT after re was driven; inverted garbage otherwise.
    logic [2:0] pv;
    logic [7:0] pd [3];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            if (pin_ctrl[7]) sram_mem[pin_ctrl[5:0]] <= pin_data;
            pv    <= {pv[1:0], pin_ctrl[6]};
            pd[0] <= sram_mem[pin_ctrl[5:0]];
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end
    assign pin_rdata = pv[2] ? pd[2] : ~pd[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model and scoreboard, sampled mid-cycle where inputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            chk("we_and_re", 32'(pin_ctrl[7] & pin_ctrl[6]), 32'd0);
            if (prev_hold) chk("rsp_hold", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, prev_data});
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            if (req_valid && req_ready) begin
                if (req_we) ref_mem[req_addr] = req_wdata;
                else        sb.push_back(ref_mem[req_addr]);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("rsp_extra", 32'd1, 32'd0);
                else                chk("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
            end
        end
    end

    // Called and returns at posedge+1; returns the cycle index of the accept edge.
    task automatic do_op(input logic we, input logic [5:0] a, input logic [7:0] d, output int acc);
        bit done = 1'b0;
        acc       = -1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 200 && !done; i++) begin
            if (rnd_rsp) rsp_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (req_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (done) acc = cyc;
        req_valid = 1'b0;
        chk("accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && !(sb.size() == 0 && req_ready); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, lat;
        bit seen;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]  = 8'(i) ^ 8'h55;
            sram_mem[i] = 8'(i) ^ 8'h55;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; rnd_rsp = 1'b0; prev_hold = 1'b0; prev_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {rsp_data, pin_data, pin_ctrl, 6'd0, req_ready, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 32'(req_ready), 32'd1);

        // 1: write then (after idle) read, with exact pin and latency checks
        do_op(1'b1, 6'd5, 8'h3A, a0);
        chk("t1_wr_ctrl", 32'(pin_ctrl), 32'h85);
        chk("t1_wr_data", 32'(pin_data), 32'h3A);
        idle(1);
        chk("t1_we_drop", 32'(pin_ctrl), 32'h05);
        idle(2);
        do_op(1'b0, 6'd5, 8'h00, a0);
        chk("t1_rd_ctrl", 32'(pin_ctrl), 32'h45);
        lat = 1;
        idle(1);
        lat++;
        chk("t1_re_drop", 32'(pin_ctrl), 32'h05);
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            idle(1);
            lat++;
        end
        chk("t1_rd_lat", 32'(lat), 32'(RD_LAT + 1));
        chk("t1_rsp_data", 32'(rsp_data), 32'h3A);
        wait_drain();
        // read-to-read throughput
        do_op(1'b0, 6'd5, 8'h00, a0);
        do_op(1'b0, 6'd0, 8'h00, a1);
        chk("t1_rd2rd", 32'(a1 - a0), 32'(RD_LAT + 2));
        wait_drain();

        // 2: back-to-back writes then read-back
        req_valid = 1'b1;
        req_we    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr  = 6'(i);
            req_wdata = 8'h10 + 8'(i);
            @(negedge clk);
            chk("t2_ready", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("t2_ctrl", 32'(pin_ctrl), 32'h80 | 32'(i));
            chk("t2_data", 32'(pin_data), 32'h10 + 32'(i));
        end
        req_valid = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) do_op(1'b0, 6'(i), 8'h00, a0);
        wait_drain();

        // 3: write@63 immediately followed by read@63 -> turnaround gap
        do_op(1'b1, 6'd63, 8'hC3, a0);
        do_op(1'b0, 6'd63, 8'h00, a1);
        chk("t3_back2back", 32'(a1 - a0), 32'd1);
        chk("t3_gap_rdy", 32'(req_ready), 32'd0);
        chk("t3_gap_ctrl", 32'(pin_ctrl), 32'h3F);
        idle(1);
        chk("t3_rd_ctrl", 32'(pin_ctrl), 32'h7F);
        wait_drain();
        chk("t3_mem", 32'(ref_mem[63]), 32'hC3);

        // 4: response held under back-pressure
        rsp_ready = 1'b0;
        do_op(1'b0, 6'd7, 8'h00, a0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            idle(1);
            seen = rsp_valid;
        end
        chk("t4_rsp_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            chk("t4_hold", {22'd0, rsp_valid, req_ready, rsp_data}, {22'd0, 1'b1, 1'b0, 8'h52});
        end
        rsp_ready = 1'b1;
        idle(1);
        chk("t4_handoff", {30'd0, rsp_valid, req_ready}, 32'd1);
        wait_drain();

        // 5: async reset in the middle of a read
        do_op(1'b0, 6'd9, 8'h00, a0);
        idle(2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", {rsp_data, pin_data, pin_ctrl, 6'd0, req_ready, rsp_valid}, 32'd0);
        sb.delete();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            seen = seen | rsp_valid;
        end
        chk("t5_no_rsp", 32'(seen), 32'd0);
        do_op(1'b1, 6'd9, 8'h66, a0);
        idle(1);
        do_op(1'b0, 6'd9, 8'h00, a0);
        wait_drain();

        // 6: random traffic against the reference memory
        rnd_rsp = 1'b1;
        for (int i = 0; i < 500; i++) begin
            do_op(1'($urandom_range(1)), 6'($urandom_range(63)), 8'($urandom_range(255)), a0);
            if ($urandom_range(3) == 0) idle(1);
        end
        rnd_rsp   = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
